// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller.
package seg_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b000_0000;
  localparam int         DEF_NDIG  = 4;
  localparam int         DEF_DIV   = 1000;

endpackage

// File: rtl/dec7seg.sv
// BCD to seven-segment decoder, segments {g,f,e,d,c,b,a} active-high.
// Codes 10..15 decode to all segments off.
module dec7seg
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  // Combinational segment lookup
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = 7'b011_1111;
      4'd1:    o_seg = 7'b000_0110;
      4'd2:    o_seg = 7'b101_1011;
      4'd3:    o_seg = 7'b100_1111;
      4'd4:    o_seg = 7'b110_0110;
      4'd5:    o_seg = 7'b110_1101;
      4'd6:    o_seg = 7'b111_1101;
      4'd7:    o_seg = 7'b000_0111;
      4'd8:    o_seg = 7'b111_1111;
      4'd9:    o_seg = 7'b110_1111;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with double-buffered digit data,
// a one-cycle anode-off gap between digits and optional leading-zero suppression.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int NDIG = DEF_NDIG,
  parameter int DIV  = DEF_DIV
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              load,
  input  logic [4*NDIG-1:0] din,
  input  logic              blank_lz,
  output logic [6:0]        seg,
  output logic [NDIG-1:0]   an,
  output logic              frame_done
);

  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV - 1) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 2);

  state_t            r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              w_commit;

  logic [4*NDIG-1:0] r_active, r_shadow;
  logic              r_pending;

  logic [3:0]        w_digit;
  logic [6:0]        w_dec_seg;
  logic [NDIG-1:0]   w_zero_above;
  logic              w_blank;

  logic [6:0]        w_seg_nxt;
  logic [NDIG-1:0]   w_an_nxt;
  logic              w_fd_nxt;
  logic [6:0]        r_seg;
  logic [NDIG-1:0]   r_an;
  logic              r_fd;

  // Scan state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic; a commit happens at the frame boundary or when scanning starts
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_commit    = 1'b0;
    case (r_state)
      IDLE: begin
        w_idx_nxt = '0;
        w_cnt_nxt = '0;
        if (enable) begin
          w_state_nxt = SCAN;
          w_commit    = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SCAN: begin
        if (!enable) begin
          w_state_nxt = IDLE;
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = GAP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      GAP: begin
        w_cnt_nxt = '0;
        if (!enable) begin
          w_state_nxt = IDLE;
          w_idx_nxt   = '0;
        end else if (r_idx == IDX_LAST) begin
          w_state_nxt = SCAN;
          w_idx_nxt   = '0;
          w_commit    = 1'b1;
        end else begin
          w_state_nxt = SCAN;
          w_idx_nxt   = r_idx + IDX_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Shadow/active buffers; a load on the commit cycle bypasses the shadow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active  <= '0;
      r_shadow  <= '0;
      r_pending <= 1'b0;
    end else if (w_commit) begin
      r_active  <= load ? din : (r_pending ? r_shadow : r_active);
      r_shadow  <= load ? din : r_shadow;
      r_pending <= 1'b0;
    end else if (load) begin
      r_shadow  <= din;
      r_pending <= 1'b1;
    end else begin
      r_active  <= r_active;
      r_shadow  <= r_shadow;
      r_pending <= r_pending;
    end
  end

  assign w_digit = r_active[{r_idx, 2'b00} +: 4];

  dec7seg u_dec7seg (
    .i_bcd (w_digit),
    .o_seg (w_dec_seg)
  );

  // w_zero_above[i]: active digits NDIG-1..i are all zero
  always_comb begin
    w_zero_above = '0;
    w_zero_above[NDIG-1] = (r_active[4*NDIG-1 -: 4] == 4'd0);
    for (int i = NDIG - 2; i >= 0; i--) begin
      w_zero_above[i] = w_zero_above[i+1] & (r_active[4*i +: 4] == 4'd0);
    end
  end

  assign w_blank = blank_lz & (r_idx != '0) & w_zero_above[r_idx];

  // Output decode for the current state; registered below
  always_comb begin
    w_seg_nxt = SEG_BLANK;
    w_an_nxt  = '1;
    w_fd_nxt  = 1'b0;
    if ((r_state == SCAN) && !w_blank) begin
      w_seg_nxt = w_dec_seg;
      w_an_nxt  = ~(NDIG'(1) << r_idx);
    end else if (r_state == GAP) begin
      w_fd_nxt  = enable & (r_idx == IDX_LAST);
    end else begin
      w_seg_nxt = SEG_BLANK;
      w_an_nxt  = '1;
    end
  end

  // Registered display outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= SEG_BLANK;
      r_an  <= '1;
      r_fd  <= 1'b0;
    end else begin
      r_seg <= w_seg_nxt;
      r_an  <= w_an_nxt;
      r_fd  <= w_fd_nxt;
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign frame_done = r_fd;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (NDIG=4, DIV=4): the driver queues the
// expected {an,seg,frame_done} per cycle and a negedge monitor pops and compares.
module tb_seg_scan_ctrl;

  localparam int NDIG = 4;
  localparam int DIV  = 4;

  localparam logic [3:0] AN_OFF = 4'b1111;
  localparam logic [6:0] BLK = 7'b0000000;
  localparam logic [6:0] S0 = 7'b0111111, S1 = 7'b0000110, S2 = 7'b1011011,
                         S3 = 7'b1001111, S4 = 7'b1100110, S5 = 7'b1101101,
                         S6 = 7'b1111101, S7 = 7'b0000111, S8 = 7'b1111111,
                         S9 = 7'b1101111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] din = 16'h0000;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.NDIG(NDIG), .DIV(DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .load       (load),
    .din        (din),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  // Monitor: outputs are compared mid-cycle against the queued expectation
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_tests++;
      if ({an, seg, frame_done} !== mon_e) begin
        n_fail++;
        $display("FAIL chk%0d an/seg/fd got %b/%b/%b want %b/%b/%b",
                 n_tests, an, seg, frame_done, mon_e.an, mon_e.seg, mon_e.fd);
      end
    end
  end

  task automatic cyc(input logic en, input logic ld, input logic [15:0] d, input logic blz,
                     input logic [3:0] ea, input logic [6:0] es, input logic ef);
    enable   = en;
    load     = ld;
    din      = d;
    blank_lz = blz;
    @(posedge clk);
    #1;
    exp_q.push_back({ea, es, ef});
  endtask

  task automatic blank_cyc(input logic en, input logic ld, input logic [15:0] d);
    cyc(en, ld, d, 1'b0, AN_OFF, BLK, 1'b0);
  endtask

  // One frame (or its first ncyc cycles); s = {s3,s2,s1,s0}, m[i]=1 -> digit i lit
  task automatic frame(input logic [27:0] s, input logic [3:0] m, input logic blz,
                       input int lp, input logic [15:0] ld, input int lp2,
                       input logic [15:0] ld2, input int ncyc);
    int          i;
    logic        ldn;
    logic [15:0] d;
    logic [3:0]  ea;
    logic [6:0]  es;
    logic        ef;
    for (int p = 0; p < ncyc; p++) begin
      i   = p / DIV;
      ldn = (p == lp) || (p == lp2);
      d   = (p == lp2) ? ld2 : ld;
      if ((p % DIV) == DIV - 1) begin
        ea = AN_OFF; es = BLK; ef = (i == NDIG - 1);
      end else if (m[i]) begin
        ea = ~(4'b0001 << i); es = s[i*7 +: 7]; ef = 1'b0;
      end else begin
        ea = AN_OFF; es = BLK; ef = 1'b0;
      end
      cyc(1'b1, ldn, d, blz, ea, es, ef);
    end
  endtask

  initial begin
    // Reset with busy inputs: outputs must stay idle
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 16'hFFFF, 1'b1, AN_OFF, BLK, 1'b0);
    rst_n = 1'b1;
    blank_cyc(1'b0, 1'b0, 16'h0000);
    blank_cyc(1'b0, 1'b0, 16'h0000);

    // Load while idle, commit on start, scan 1234
    blank_cyc(1'b0, 1'b1, 16'h1234);
    blank_cyc(1'b1, 1'b0, 16'h0000);
    frame({S1, S2, S3, S4}, 4'b1111, 1'b0, -1, 16'h0, -1, 16'h0, 16);

    // Mid-frame load does not tear; new data appears next frame
    frame({S1, S2, S3, S4}, 4'b1111, 1'b0, 8, 16'h5678, -1, 16'h0, 16);
    frame({S5, S6, S7, S8}, 4'b1111, 1'b0, 15, 16'h0007, -1, 16'h0, 16);

    // Leading-zero suppression; loads on the boundary commit directly
    frame({BLK, BLK, BLK, S7}, 4'b0001, 1'b1, 15, 16'h0000, -1, 16'h0, 16);
    frame({BLK, BLK, BLK, S0}, 4'b0001, 1'b1, 15, 16'h0107, -1, 16'h0, 16);
    frame({BLK, S1, S0, S7}, 4'b0111, 1'b1, 15, 16'h00A9, -1, 16'h0, 16);

    // Invalid code lit but dark; two loads in one frame, last wins
    frame({S0, S0, BLK, S9}, 4'b1111, 1'b0, 2, 16'h4321, 6, 16'h9876, 16);

    // Enable drop during digit 2 with a pending load
    frame({S9, S8, S7, S6}, 4'b1111, 1'b0, 3, 16'h2468, -1, 16'h0, 9);
    cyc(1'b0, 1'b0, 16'h0000, 1'b0, 4'b1011, S8, 1'b0);
    for (int k = 0; k < 3; k++) blank_cyc(1'b0, 1'b0, 16'h0000);
    blank_cyc(1'b1, 1'b0, 16'h0000);
    frame({S2, S4, S6, S8}, 4'b1111, 1'b0, 5, 16'h1357, -1, 16'h0, 10);

    // Asynchronous reset mid-frame drops the pending load and clears active
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    blank_cyc(1'b1, 1'b1, 16'hFFFF);
    blank_cyc(1'b1, 1'b1, 16'hFFFF);
    rst_n = 1'b1;
    blank_cyc(1'b0, 1'b0, 16'h0000);
    blank_cyc(1'b1, 1'b0, 16'h0000);
    frame({S0, S0, S0, S0}, 4'b1111, 1'b0, -1, 16'h0, -1, 16'h0, 16);

    load   = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain queue left=%0d want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1);
  end

endmodule
